// File: rtl/pci_burst_target.sv
// pci_burst_target
//   PCI-style burst target with a DEPTH-word internal memory. Decodes a naturally
//   aligned address window at BASE_ADDR and accepts single or burst reads and writes.
//   Writes are byte-masked by cbe_n. The word index wraps at the end of the window.
//   DEVSEL# timing (DEVSEL_DLY) and the initial TRDY# wait count (INIT_WAIT) are
//   programmable.
// Ports
//   clk       bus clock, all logic on posedge
//   rst       synchronous reset, active high
//   frame_n   FRAME#, active low
//   irdy_n    IRDY#, active low
//   cbe_n     command in the address phase, byte enables (active low) in data phases
//   ad_i      AD bus as sampled
//   ad_o      registered read data for AD
//   ad_oe     1 = target drives AD
//   devsel_n  DEVSEL#, active low
//   trdy_n    TRDY#, active low
//   busy      1 whenever the FSM is not idle
//   xfer_cnt  transfers in the current or last claimed transaction, saturating at 255
module pci_burst_target #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0010,
  parameter int          DEPTH      = 4,
  parameter int          ADDR_W     = $clog2(DEPTH),
  parameter int          DEVSEL_DLY = 0,
  parameter int          INIT_WAIT  = 0,
  parameter logic [3:0]  CMD_READ   = 4'b0010,
  parameter logic [3:0]  CMD_WRITE  = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] ad_i,
  output logic [31:0] ad_o,
  output logic        ad_oe,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        busy,
  output logic [7:0]  xfer_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    WAIT   = 3'd2,
    DATA   = 3'd3,
    TURN   = 3'd4,
    IGNORE = 3'd5
  } state_t;

  state_t            state_r;
  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] idx_r;
  logic              is_read_r;
  logic [2:0]        dly_cnt_r;
  logic [31:0]       ad_o_r;
  logic              ad_oe_r;
  logic              devsel_n_r;
  logic              trdy_n_r;
  logic              busy_r;
  logic [7:0]        xfer_cnt_r;

  logic              cmd_ok_s;
  logic              addr_hit_s;
  logic              xfer_s;
  logic              abort_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] idx_inc_s;
  logic [ADDR_W-1:0] rd_idx_s;
  logic [31:0]       rd_data_s;

  assign ad_o     = ad_o_r;
  assign ad_oe    = ad_oe_r;
  assign devsel_n = devsel_n_r;
  assign trdy_n   = trdy_n_r;
  assign busy     = busy_r;
  assign xfer_cnt = xfer_cnt_r;

  // Address decode, transfer qualification and single read-port address select.
  always_comb begin
    cmd_ok_s   = (cbe_n == CMD_READ) || (cbe_n == CMD_WRITE);
    addr_hit_s = (ad_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    xfer_s     = (state_r == DATA) && !irdy_n && !trdy_n_r;
    abort_s    = frame_n && irdy_n;
    wr_en_s    = xfer_s && !is_read_r;
    idx_inc_s  = idx_r + 1'b1;
    // In DATA the read port looks one word ahead so ad_o is ready for the next
    // transfer; before that it preloads the first word.
    if (state_r == DATA) begin
      rd_idx_s = idx_inc_s;
    end else begin
      rd_idx_s = idx_r;
    end
    rd_data_s = mem_r[rd_idx_s];
  end

  // Byte-masked write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (!cbe_n[b]) begin
          mem_r[idx_r][8*b +: 8] <= ad_i[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      devsel_n_r <= 1'b1;
      trdy_n_r   <= 1'b1;
      ad_oe_r    <= 1'b0;
      ad_o_r     <= 32'h0000_0000;
      busy_r     <= 1'b0;
      xfer_cnt_r <= 8'd0;
      idx_r      <= '0;
      is_read_r  <= 1'b0;
      dly_cnt_r  <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!frame_n) begin
            is_read_r <= (cbe_n == CMD_READ);
            idx_r     <= ad_i[ADDR_W+1:2];
            dly_cnt_r <= 3'd0;
            busy_r    <= 1'b1;
            if (cmd_ok_s && addr_hit_s) begin
              xfer_cnt_r <= 8'd0;
              state_r    <= DECODE;
            end else begin
              state_r <= IGNORE;
            end
          end
        end
        IGNORE: begin
          if (frame_n && irdy_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        DECODE: begin
          if (abort_s) begin
            devsel_n_r <= 1'b1;
            trdy_n_r   <= 1'b1;
            ad_oe_r    <= 1'b0;
            state_r    <= TURN;
          end else begin
            // Reads start driving AD one clock after the address phase, which
            // leaves the master a turnaround cycle.
            if (is_read_r) begin
              ad_oe_r <= 1'b1;
              ad_o_r  <= rd_data_s;
            end
            if (dly_cnt_r == 3'(DEVSEL_DLY)) begin
              devsel_n_r <= 1'b0;
              dly_cnt_r  <= 3'd0;
              state_r    <= WAIT;
            end else begin
              dly_cnt_r <= dly_cnt_r + 3'd1;
            end
          end
        end
        WAIT: begin
          if (abort_s) begin
            devsel_n_r <= 1'b1;
            trdy_n_r   <= 1'b1;
            ad_oe_r    <= 1'b0;
            state_r    <= TURN;
          end else if (dly_cnt_r == 3'(INIT_WAIT)) begin
            trdy_n_r <= 1'b0;
            state_r  <= DATA;
          end else begin
            dly_cnt_r <= dly_cnt_r + 3'd1;
          end
        end
        DATA: begin
          if (xfer_s) begin
            idx_r <= idx_inc_s;
            if (xfer_cnt_r != 8'hFF) begin
              xfer_cnt_r <= xfer_cnt_r + 8'd1;
            end
            if (is_read_r) begin
              ad_o_r <= rd_data_s;
            end
            // frame_n high on a transfer marks the final data phase.
            if (frame_n) begin
              devsel_n_r <= 1'b1;
              trdy_n_r   <= 1'b1;
              ad_oe_r    <= 1'b0;
              state_r    <= TURN;
            end
          end else if (abort_s) begin
            devsel_n_r <= 1'b1;
            trdy_n_r   <= 1'b1;
            ad_oe_r    <= 1'b0;
            state_r    <= TURN;
          end
        end
        TURN: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          devsel_n_r <= 1'b1;
          trdy_n_r   <= 1'b1;
          ad_oe_r    <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_burst_target.sv
// tb_pci_burst_target
//   Self-checking bench for pci_burst_target. A master task drives address and data
//   phases; a word-array reference memory and an edge count since the address phase
//   give the expected memory contents, DEVSEL#/TRDY# timing, ad_oe and xfer_cnt.
module tb_pci_burst_target;

  localparam logic [31:0] BASE  = 32'h0000_0010;
  localparam int          DEPTH = 4;
  localparam int          DLY   = 0;
  localparam int          IWAIT = 2;
  localparam logic [3:0]  CRD   = 4'b0010;
  localparam logic [3:0]  CWR   = 4'b0011;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_n;
  logic        irdy_n;
  logic [3:0]  cbe_n;
  logic [31:0] ad_i;
  logic [31:0] ad_o;
  logic        ad_oe;
  logic        devsel_n;
  logic        trdy_n;
  logic        busy;
  logic [7:0]  xfer_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd_q   [16];
  logic [3:0]  be_q   [16];
  int          wait_q [16];

  pci_burst_target #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .DEVSEL_DLY(DLY),
    .INIT_WAIT (IWAIT),
    .CMD_READ  (CRD),
    .CMD_WRITE (CWR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .frame_n (frame_n),
    .irdy_n  (irdy_n),
    .cbe_n   (cbe_n),
    .ad_i    (ad_i),
    .ad_o    (ad_o),
    .ad_oe   (ad_oe),
    .devsel_n(devsel_n),
    .trdy_n  (trdy_n),
    .busy    (busy),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      wd_q[i]   = $urandom;
      be_q[i]   = 4'h0;
      wait_q[i] = 0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_devsel"}, devsel_n, 32'd1);
    check_val({tag, "_trdy"}, trdy_n, 32'd1);
    check_val({tag, "_ad_oe"}, ad_oe, 32'd0);
  endtask

  // One master transaction. rst_at >= 0 pulses reset once that many transfers are done.
  task automatic xact(input logic [3:0] cmd, input logic [31:0] addr, input int n, input int rst_at);
    bit   hit;
    bit   wr;
    int   idx;
    int   e;
    int   sent;
    int   budget;
    logic tr_obs;
    hit = ((cmd == CRD) || (cmd == CWR)) && (addr >= BASE) && (addr < BASE + 32'(DEPTH * 4));
    wr  = (cmd == CWR);
    idx = int'((addr - BASE) >> 2) % DEPTH;
    @(negedge clk);
    frame_n = 1'b0;
    irdy_n  = 1'b1;
    cbe_n   = cmd;
    ad_i    = addr;
    @(posedge clk);
    if (!hit) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check_idle_outputs("ign");
        check_val("ign_busy", busy, 32'd1);
        frame_n = (c == 3);
        irdy_n  = 1'b0;
        cbe_n   = 4'h0;
        ad_i    = $urandom;
      end
      @(negedge clk);
      check_val("ign_busy_end", busy, 32'd1);
      frame_n = 1'b1;
      irdy_n  = 1'b1;
      cbe_n   = 4'hF;
      @(negedge clk);
      check_val("ign_idle", busy, 32'd0);
      return;
    end
    e      = 0;
    sent   = 0;
    budget = 0;
    while (sent < n) begin
      @(negedge clk);
      if (budget > 60) begin
        check_val("timeout", sent, n);
        break;
      end
      budget++;
      check_val("devsel", devsel_n, (e >= 1 + DLY) ? 32'd0 : 32'd1);
      check_val("trdy", trdy_n, (e >= 2 + DLY + IWAIT) ? 32'd0 : 32'd1);
      check_val("ad_oe", ad_oe, (wr || e < 1) ? 32'd0 : 32'd1);
      check_val("busy", busy, 32'd1);
      check_val("xfer_cnt", xfer_cnt, sent);
      if (!wr && e >= 2 + DLY + IWAIT) begin
        check_val("rdata", ad_o, ref_mem[idx]);
      end
      if (rst_at == sent) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst");
        check_val("rst_ad_o", ad_o, 32'd0);
        check_val("rst_busy", busy, 32'd0);
        check_val("rst_xfer", xfer_cnt, 32'd0);
        rst     = 1'b0;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        cbe_n   = 4'hF;
        @(negedge clk);
        check_val("rst_stay_idle", busy, 32'd0);
        return;
      end
      tr_obs = trdy_n;
      if (wait_q[sent] > 0) begin
        wait_q[sent]--;
        irdy_n  = 1'b1;
        frame_n = 1'b0;
        ad_i    = $urandom;
      end else begin
        irdy_n  = 1'b0;
        frame_n = (sent == n - 1);
        cbe_n   = wr ? be_q[sent] : 4'h0;
        ad_i    = wr ? wd_q[sent] : $urandom;
      end
      @(posedge clk);
      e++;
      if (!irdy_n && !tr_obs) begin
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            if (!be_q[sent][b]) ref_mem[idx][8*b +: 8] = wd_q[sent][8*b +: 8];
          end
        end
        idx = (idx + 1) % DEPTH;
        sent++;
      end
    end
    @(negedge clk);
    check_idle_outputs("end");
    check_val("end_busy_turn", busy, 32'd1);
    check_val("end_xfer", xfer_cnt, n);
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    cbe_n   = 4'hF;
    @(negedge clk);
    check_val("end_idle", busy, 32'd0);
    check_val("end_xfer_hold", xfer_cnt, n);
  endtask

  initial begin
    logic [3:0]  r_cmd;
    logic [31:0] r_addr;
    int          sel;
    rst     = 1'b1;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    cbe_n   = 4'hF;
    ad_i    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check_val("reset_ad_o", ad_o, 32'd0);
    check_val("reset_busy", busy, 32'd0);
    check_val("reset_xfer", xfer_cnt, 32'd0);
    rst = 1'b0;

    // Burst write 1001..1004 at the window base, then read it back.
    clear_plan();
    for (int i = 0; i < 4; i++) wd_q[i] = 32'd1001 + 32'(i);
    xact(CWR, 32'h10, 4, -1);
    xact(CRD, 32'h10, 4, -1);

    // Wrapping write from idx 2, length 3.
    clear_plan();
    wd_q[0] = 32'hA0A0_0002;
    wd_q[1] = 32'hA0A0_0003;
    wd_q[2] = 32'hA0A0_0000;
    xact(CWR, 32'h18, 3, -1);
    xact(CRD, 32'h10, 4, -1);

    // Byte-enabled write over a zeroed word.
    clear_plan();
    wd_q[0] = 32'h0;
    xact(CWR, 32'h10, 1, -1);
    wd_q[0] = 32'hAABB_CCDD;
    be_q[0] = 4'b1010;
    xact(CWR, 32'h10, 1, -1);
    xact(CRD, 32'h10, 1, -1);

    // Out-of-window address and unsupported command are ignored.
    clear_plan();
    xact(CWR, 32'h100, 2, -1);
    xact(4'b0110, 32'h10, 2, -1);
    xact(CRD, 32'h10, 4, -1);

    // Randomised traffic.
    for (int t = 0; t < 24; t++) begin
      clear_plan();
      sel = int'($urandom_range(0, 4));
      r_cmd = (sel < 2) ? CRD : ((sel < 4) ? CWR : 4'b0110);
      if ($urandom_range(0, 4) == 0) r_addr = 32'h100 + 32'(4 * $urandom_range(0, 3));
      else r_addr = BASE + 32'(4 * $urandom_range(0, 3));
      for (int i = 0; i < 16; i++) begin
        be_q[i] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) wait_q[i] = int'($urandom_range(1, 2));
      end
      xact(r_cmd, r_addr, int'($urandom_range(1, 6)), -1);
    end

    // Master wait mid-read, then reset mid-burst; memory must survive.
    clear_plan();
    wait_q[2] = 2;
    xact(CRD, 32'h10, 4, 3);
    clear_plan();
    xact(CRD, 32'h14, 4, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
